// File: rtl/seg7_scan_decoder.sv
// Recovers hex digit values from a scanned, multiplexed 7-segment display bus.
// Each digit dwell is captured once after its {sel,seg} pattern has been stable for SETTLE samples.
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     valid,
  output logic                  err,
  output logic                  frame
);

  typedef enum logic [1:0] {IDLE, SETTLING, HOLD} state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  // Bit 4 of the result flags a legal glyph; bits 3:0 carry the nibble.
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'b1111110: return 5'h10;
      7'b0110000: return 5'h11;
      7'b1101101: return 5'h12;
      7'b1111001: return 5'h13;
      7'b0110011: return 5'h14;
      7'b1011011: return 5'h15;
      7'b1011111: return 5'h16;
      7'b1110000: return 5'h17;
      7'b1111111: return 5'h18;
      7'b1111011: return 5'h19;
      7'b1110111: return 5'h1A;
      7'b0011111: return 5'h1B;
      7'b1001110: return 5'h1C;
      7'b0111101: return 5'h1D;
      7'b1001111: return 5'h1E;
      7'b1000111: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  state_t              state;
  logic [DIGITS+6:0]   prev;
  logic [7:0]          cnt;
  logic [DIGITS-1:0]   seen;

  logic [DIGITS+6:0]   cur;
  logic                same;
  logic                onehot;
  logic [7:0]          cnt_next;
  logic                capture;
  logic [4:0]          glyph;
  logic [DIGITS-1:0]   seen_upd;
  logic                frame_hit;
  state_t              state_next;

  always_comb begin
    cur      = {sel, seg};
    same     = (cur == prev);
    onehot   = $onehot(sel);
    cnt_next = 8'd1;
    if (same)
      cnt_next = (cnt >= SETTLE_CNT) ? SETTLE_CNT : cnt + 8'd1;
    // A HOLD dwell that is still unchanged has already been captured.
    capture   = onehot && (cnt_next == SETTLE_CNT) && !(state == HOLD && same);
    glyph     = decode_glyph(seg);
    seen_upd  = seen | sel;
    frame_hit = capture && (&seen_upd);

    state_next = SETTLING;
    if (!onehot)
      state_next = IDLE;
    else if (capture || (state == HOLD && same))
      state_next = HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev  <= '0;
      cnt   <= '0;
      seen  <= '0;
      value <= '0;
      valid <= '0;
      err   <= 1'b0;
      frame <= 1'b0;
    end else begin
      prev  <= cur;
      cnt   <= cnt_next;
      state <= state_next;
      err   <= capture && !glyph[4];
      frame <= frame_hit;
      if (capture) begin
        seen <= frame_hit ? '0 : seen_upd;
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            valid[i] <= glyph[4];
            if (glyph[4])
              value[4*i +: 4] <= glyph[3:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected output events,
// an independent monitor pops and compares them whenever the outputs move or pulse.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int SETTLE = 4;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic [15:0] value;
  logic [3:0]  valid;
  logic        err;
  logic        frame;

  seg7_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .seg   (seg),
    .sel   (sel),
    .value (value),
    .valid (valid),
    .err   (err),
    .frame (frame)
  );

  typedef struct {
    int          cyc;
    logic [15:0] value;
    logic [3:0]  valid;
    logic        err;
    logic        frame;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [15:0] mvalue = '0;
  logic [3:0]  mvalid = '0;
  logic [3:0]  mseen  = '0;

  // Hand-written glyph table, index = nibble.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] lookup(input logic [6:0] g);
    logic [4:0] r = 5'h00;
    for (int i = 0; i < 16; i++)
      if (glyph[i] == g) r = {1'b1, 4'(i)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Drive one dwell; when cap is set a capture is expected on the SETTLE-th edge.
  task automatic dwell(input logic [3:0] s, input logic [6:0] g, input int n, input bit cap);
    exp_t        e;
    int          d;
    logic [4:0]  dec;
    logic [15:0] nv;
    logic [3:0]  nl;
    sel = s;
    seg = g;
    if (cap) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (s[i]) d = i;
      dec = lookup(g);
      nv = mvalue;
      nl = mvalid;
      nl[d] = dec[4];
      if (dec[4]) nv[4*d +: 4] = dec[3:0];
      mseen[d] = 1'b1;
      e.frame = &mseen;
      if (e.frame) mseen = '0;
      e.err   = !dec[4];
      e.cyc   = cyc + SETTLE;
      e.value = nv;
      e.valid = nl;
      if (nv != mvalue || nl != mvalid || e.err || e.frame) q.push_back(e);
      mvalue = nv;
      mvalid = nl;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any visible output activity must match the head of the queue.
  logic [19:0] last = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last = '0;
    end else if (err || frame || {value, valid} != last) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d value=%h valid=%h err=%b frame=%b",
                 cyc, value, valid, err, frame);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL event_cycle actual=%0d expected=%0d", cyc, e.cyc);
        end
        checks++;
        if ({value, valid, err, frame} !== {e.value, e.valid, e.err, e.frame}) begin
          errors++;
          $display("FAIL event_data actual value=%h valid=%h err=%b frame=%b expected value=%h valid=%h err=%b frame=%b",
                   value, valid, err, frame, e.value, e.valid, e.err, e.frame);
        end
      end
      last = {value, valid};
    end
  end

  initial begin
    logic [4:0] dec;
    rst = 1'b1;
    sel = '0;
    seg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {10'd0, value, valid, err, frame}, 32'd0);
    rst = 1'b0;

    // Full frame of digits 0..3 showing 0,1,2,3.
    dwell(4'b0001, 7'b1111110, 8, 1);
    dwell(4'b0010, 7'b0110000, 8, 1);
    dwell(4'b0100, 7'b1101101, 8, 1);
    dwell(4'b1000, 7'b1111001, 8, 1);
    chk("frame_value", {16'd0, value}, 32'h3210);
    chk("frame_valid", {28'd0, valid}, 32'hF);

    // Reset asserted mid-settle clears everything at once.
    dwell(4'b0001, 7'b1111001, 2, 0);
    rst = 1'b1;
    #1;
    chk("async_reset", {10'd0, value, valid, err, frame}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mvalue = '0;
    mvalid = '0;
    mseen  = '0;
    dwell(4'b0001, 7'b1111001, 6, 1);

    // Settle glitch: toggling seg never settles, then the final hold captures 5.
    for (int k = 0; k < 2; k++) begin
      dwell(4'b0010, 7'b0110011, 2, 0);
      dwell(4'b0010, 7'b1011011, 2, 0);
    end
    dwell(4'b0010, 7'b0110011, 2, 0);
    dwell(4'b0010, 7'b1011011, 6, 1);
    chk("glitch_nibble", {28'd0, value[7:4]}, 32'h5);

    // Digit2 shows A, then an illegal pattern keeps A but drops valid.
    dwell(4'b0100, 7'b1110111, 6, 1);
    dwell(4'b0100, 7'b0000001, 8, 1);
    chk("illegal_keeps_value", {28'd0, value[11:8]}, 32'hA);
    chk("illegal_valid", {31'd0, valid[2]}, 32'h0);

    // Blanking and multi-hot selects capture nothing.
    dwell(4'b0000, 7'b1111111, 20, 0);
    dwell(4'b0011, 7'b1111111, 20, 0);

    // Long dwell: single capture of d on digit3, completing the frame.
    dwell(4'b1000, 7'b0111101, 100, 1);
    chk("hold_nibble", {28'd0, value[15:12]}, 32'hD);

    for (int i = 0; i < 16; i++) dwell(4'b0001, glyph[i], 6, 1);
    for (int c = 0; c < 128; c++) begin
      dec = lookup(7'(c));
      if (!dec[4]) dwell(4'b0001, 7'(c), 6, 1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
